// File: rtl/duty_ramp.sv
// duty_ramp: steps a PWM duty value toward a commanded target at a fixed
// interval, then pulses done.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   cmd_valid      a ramp command is present
//   cmd_ready      command can be accepted this cycle (IDLE and no abort)
//   cmd_target     requested final duty, clamped to [DUTY_MIN, DUTY_MAX]
//   cmd_step       duty increment applied per step
//   cmd_rate       PRESCALE time units between steps
//   abort          stop the ramp and hold the present duty
//   duty           registered duty value for the PWM counter
//   busy           ramp in progress (state is not IDLE)
//   done           one-cycle pulse when duty reaches the target
module duty_ramp #(
    parameter int PRESCALE  = 50000,
    parameter int INIT_DUTY = 15,
    parameter int DUTY_MIN  = 5,
    parameter int DUTY_MAX  = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_target,
    input  logic [3:0] cmd_step,
    input  logic [7:0] cmd_rate,
    input  logic       abort,
    output logic [7:0] duty,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] L_PMAX = PW'(PRESCALE - 1);
    localparam logic [7:0]    L_MIN  = 8'(DUTY_MIN);
    localparam logic [7:0]    L_MAX  = 8'(DUTY_MAX);
    localparam logic [7:0]    L_INIT = 8'(INIT_DUTY);

    state_t          r_state;
    logic [7:0]      r_duty;
    logic            r_done;
    logic [7:0]      r_target;
    logic [3:0]      r_step;
    logic [7:0]      r_rate;
    logic            r_imm;
    logic [PW-1:0]   r_presc;
    logic [7:0]      r_ivl;

    logic            w_accept;
    logic [7:0]      w_clamped;
    logic            w_imm;
    logic signed [8:0] w_diff;
    logic [7:0]      w_mag;
    logic [7:0]      w_inc;
    logic [7:0]      w_next;
    logic            w_wrap;
    logic            w_last;

    assign cmd_ready = (r_state == IDLE) && !abort;
    assign busy      = (r_state != IDLE);
    assign duty      = r_duty;
    assign done      = r_done;

    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_clamped = cmd_target;
        if (cmd_target < L_MIN) begin
            w_clamped = L_MIN;
        end else if (cmd_target > L_MAX) begin
            w_clamped = L_MAX;
        end
    end

    // Nothing to ramp: jump straight to the target in a single STEP.
    assign w_imm = (cmd_step == 4'd0) || (cmd_rate == 8'd0) ||
                   (w_clamped == r_duty);

    // Signed distance to target; the step is limited to its magnitude so
    // duty lands exactly on the target and can never wrap.
    assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_duty});
    assign w_mag  = w_diff[8] ? 8'(-w_diff) : w_diff[7:0];
    assign w_inc  = ({4'd0, r_step} < w_mag) ? {4'd0, r_step} : w_mag;

    always_comb begin
        w_next = r_duty;
        if (r_imm) begin
            w_next = r_target;
        end else if (w_diff[8]) begin
            w_next = r_duty - w_inc;
        end else begin
            w_next = r_duty + w_inc;
        end
    end

    assign w_wrap = (r_presc == L_PMAX);
    assign w_last = (r_ivl == (r_rate - 8'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_duty   <= L_INIT;
            r_done   <= 1'b0;
            r_target <= 8'd0;
            r_step   <= 4'd0;
            r_rate   <= 8'd0;
            r_imm    <= 1'b0;
            r_presc  <= '0;
            r_ivl    <= 8'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_target <= w_clamped;
                        r_step   <= cmd_step;
                        r_rate   <= cmd_rate;
                        r_imm    <= w_imm;
                        r_presc  <= '0;
                        r_ivl    <= 8'd0;
                        r_state  <= w_imm ? STEP : WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_wrap) begin
                        r_presc <= '0;
                        if (w_last) begin
                            r_ivl   <= 8'd0;
                            r_state <= STEP;
                        end else begin
                            r_ivl <= r_ivl + 8'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                STEP: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_duty <= w_next;
                        if (w_next == r_target) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_presc <= '0;
                            r_ivl   <= 8'd0;
                            r_state <= WAIT;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: directed checks of duty_ramp with PRESCALE=4.
// Edge counts c are measured from the command acceptance edge (c=0).
module tb_duty_ramp;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [3:0] cmd_step;
    logic [7:0] cmd_rate;
    logic       abort;
    logic [7:0] duty;
    logic       busy;
    logic       done;

    int errors;
    int checks;

    duty_ramp #(
        .PRESCALE (4),
        .INIT_DUTY(15),
        .DUTY_MIN (5),
        .DUTY_MAX (25)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .cmd_step  (cmd_step),
        .cmd_rate  (cmd_rate),
        .abort     (abort),
        .duty      (duty),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] t, input logic [3:0] s,
                        input logic [7:0] r);
        cmd_target = t;
        cmd_step   = s;
        cmd_rate   = r;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        abort = 1'b0;
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (duty !== 8'd15) begin
            errors++;
            $display("FAIL reset_duty got %0d want 15", duty);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready got %b want 0", cmd_ready);
        end
        abort = 1'b0;
    endtask

    // Up ramp 15->21 by 2, rate 1: STEP edge at c=4,9,14, duty lands one
    // edge later at c=5,10,15.
    task automatic test_up_ramp();
        logic [7:0] ed;
        do_reset();
        send(8'd21, 4'd2, 8'd1);
        checks++;
        if (busy !== 1'b1 || duty !== 8'd15) begin
            errors++;
            $display("FAIL up_start busy=%b duty=%0d want 1 15", busy, duty);
        end
        for (int c = 1; c <= 20; c++) begin
            tick();
            ed = (c < 5) ? 8'd15 : (c < 10) ? 8'd17 : (c < 15) ? 8'd19 : 8'd21;
            checks++;
            if (duty !== ed || done !== (c == 15) || busy !== (c < 15)) begin
                errors++;
                $display("FAIL up_c%0d duty=%0d done=%b busy=%b want %0d %b %b",
                         c, duty, done, busy, ed, (c == 15), (c < 15));
            end
        end
    endtask

    // Target 200 clamps to 25; rate 2 gives 8 WAIT cycles + 1 STEP.
    task automatic test_clamp();
        logic [7:0] ed;
        do_reset();
        send(8'd200, 4'd4, 8'd2);
        for (int c = 1; c <= 32; c++) begin
            tick();
            ed = (c < 9) ? 8'd15 : (c < 18) ? 8'd19 : (c < 27) ? 8'd23 : 8'd25;
            checks++;
            if (duty !== ed || done !== (c == 27) || busy !== (c < 27)) begin
                errors++;
                $display("FAIL clamp_c%0d duty=%0d done=%b busy=%b want %0d %b %b",
                         c, duty, done, busy, ed, (c == 27), (c < 27));
            end
        end
    endtask

    // Runs straight after test_clamp with duty at 25.
    task automatic test_immediate();
        send(8'd5, 4'd0, 8'd3);
        checks++;
        if (busy !== 1'b1 || duty !== 8'd25 || done !== 1'b0) begin
            errors++;
            $display("FAIL imm_c0 busy=%b duty=%0d done=%b want 1 25 0",
                     busy, duty, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || duty !== 8'd5 || done !== 1'b1) begin
            errors++;
            $display("FAIL imm_c1 busy=%b duty=%0d done=%b want 0 5 1",
                     busy, duty, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || duty !== 8'd5) begin
            errors++;
            $display("FAIL imm_c2 done=%b duty=%0d want 0 5", done, duty);
        end
        // Target 3 clamps to 5 == duty: immediate even with step and rate set.
        send(8'd3, 4'd1, 8'd1);
        tick();
        checks++;
        if (busy !== 1'b0 || duty !== 8'd5 || done !== 1'b1) begin
            errors++;
            $display("FAIL low_clamp busy=%b duty=%0d done=%b want 0 5 1",
                     busy, duty, done);
        end
    endtask

    task automatic test_abort();
        int seen;
        do_reset();
        send(8'd25, 4'd4, 8'd1);
        for (int c = 1; c <= 6; c++) tick();
        checks++;
        if (duty !== 8'd19 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre duty=%0d busy=%b want 19 1", duty, busy);
        end
        abort = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || duty !== 8'd19 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait busy=%b duty=%0d done=%b want 0 19 0",
                     busy, duty, done);
        end
        cmd_target = 8'd10;
        cmd_step   = 4'd1;
        cmd_rate   = 8'd0;
        cmd_valid  = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || duty !== 8'd19) begin
            errors++;
            $display("FAIL abort_idle busy=%b duty=%0d want 0 19", busy, duty);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done === 1'b1 || duty !== 8'd19) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_hold bad_cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        send(8'd25, 4'd4, 8'd1);
        for (int c = 1; c <= 4; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (duty !== 8'd15 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid duty=%0d busy=%b done=%b want 15 0 0",
                     duty, busy, done);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done === 1'b1 || duty !== 8'd15) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_after bad_cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int rdy;
        do_reset();
        send(8'd21, 4'd2, 8'd1);
        cmd_target = 8'd10;
        cmd_step   = 4'd1;
        cmd_rate   = 8'd1;
        cmd_valid  = 1'b1;
        rdy = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (cmd_ready !== 1'b0) rdy++;
        end
        checks++;
        if (rdy != 0) begin
            errors++;
            $display("FAIL busy_ready ready_cycles=%0d want 0", rdy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || duty !== 8'd21 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done done=%b duty=%0d ready=%b want 1 21 1",
                     done, duty, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || duty !== 8'd21 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b duty=%0d done=%b want 1 21 0",
                     busy, duty, done);
        end
        for (int c = 1; c <= 5; c++) tick();
        checks++;
        if (duty !== 8'd20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_down duty=%0d busy=%b want 20 1", duty, busy);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 8'd0;
        cmd_step   = 4'd0;
        cmd_rate   = 8'd0;
        abort      = 1'b0;
        test_reset();
        test_up_ramp();
        test_clamp();
        test_immediate();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
